// File: rtl/sram_like_slave.sv
// Responder for the core's SRAM-like req/addr_ok/data_ok port group.
// Word memory with byte strobes and in-order responses after a fixed latency.
module sram_like_slave #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned LATENCY         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall_in,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned PtrW  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned LatW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTSTANDING);
  localparam logic [LatW-1:0] LatLoad = LatW'(LATENCY - 1);

  logic [31:0]       mem    [Depth];
  logic [31:0]       fifo_q [MAX_OUTSTANDING];

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              full, empty, push, pop;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       push_data;
  logic              unused_bits;

  assign idx       = addr[ADDR_W+1:2];
  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  assign addr_ok   = req & ~stall_in & ~full & ~reset;
  assign push      = addr_ok;
  assign pop       = data_ok_q;
  // Read data is captured at acceptance so later writes cannot disturb it.
  assign push_data = wr ? 32'h0 : mem[idx];

  assign data_ok   = data_ok_q;
  assign rdata     = rdata_q;

  // size is informational only; upper address bits alias.
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    lat_d     = lat_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    // A new head starts its latency countdown; otherwise count down the current one.
    if ((push && empty) || (pop && (count_d != '0))) begin
      lat_d = LatLoad;
    end else if (!empty && (lat_q != '0)) begin
      lat_d = lat_q - 1'b1;
    end

    // Register the response one edge early so data_ok appears when the head is due.
    data_ok_d = (count_d != '0) && (lat_d == '0);
    if (data_ok_d) begin
      rdata_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : fifo_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      lat_q     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      lat_q     <= lat_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three instances (LATENCY 2, 8, 1) against a
// due-time response-queue model, plus directed literal checks.
module tb_sram_like_slave;

  typedef struct {
    logic [31:0] data;
    bit          known;
    longint      due;
  } resp_t;

  logic        clk;
  logic        rst      [3];
  logic        req      [3];
  logic        wr       [3];
  logic [1:0]  size     [3];
  logic [3:0]  wstrb    [3];
  logic [31:0] addr     [3];
  logic [31:0] wdata    [3];
  logic        stall_in [3];
  logic        addr_ok  [3];
  logic        data_ok  [3];
  logic [31:0] rdata    [3];

  longint cyc   = 0;
  int     total = 0;
  int     bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 8 : 1;

    sram_like_slave #(
      .ADDR_W         (10),
      .MAX_OUTSTANDING(4),
      .LATENCY        (L)
    ) u_dut (
      .clk     (clk),
      .reset   (rst[g]),
      .req     (req[g]),
      .wr      (wr[g]),
      .size    (size[g]),
      .wstrb   (wstrb[g]),
      .addr    (addr[g]),
      .wdata   (wdata[g]),
      .stall_in(stall_in[g]),
      .addr_ok (addr_ok[g]),
      .data_ok (data_ok[g]),
      .rdata   (rdata[g])
    );

    // Model: each accepted request is due L cycles after acceptance, or L cycles
    // after the previously queued response if one is still pending.
    resp_t       q[$];
    logic [31:0] mmem [1024];
    bit   [3:0]  mkb  [1024];
    logic [31:0] last_rd    = 32'h0;
    bit          last_known = 1'b0;

    always @(negedge clk) begin
      bit          exp_aok;
      bit          exp_dok;
      resp_t       e;
      int unsigned idx;
      if (cyc >= 1) begin
        exp_aok = req[g] && !stall_in[g] && !rst[g] && (q.size() < 4);
        exp_dok = (q.size() != 0) && (q[0].due == cyc);
        chk($sformatf("m%0d addr_ok", g), 32'(addr_ok[g]), 32'(exp_aok));
        chk($sformatf("m%0d data_ok", g), 32'(data_ok[g]), 32'(exp_dok));
        if (exp_dok) begin
          last_rd    = q[0].data;
          last_known = q[0].known;
        end
        if (last_known) chk($sformatf("m%0d rdata", g), rdata[g], last_rd);
        if (rst[g]) begin
          q.delete();
          last_rd    = 32'h0;
          last_known = 1'b1;
        end else begin
          if (exp_aok) begin
            idx   = (addr[g] >> 2) % 1024;
            e.due = ((q.size() != 0) ? q[$].due : cyc) + longint'(L);
            if (wr[g]) begin
              e.data  = 32'h0;
              e.known = 1'b1;
              for (int b = 0; b < 4; b++) begin
                if (wstrb[g][b]) begin
                  mmem[idx][8*b +: 8] = wdata[g][8*b +: 8];
                  mkb[idx][b]         = 1'b1;
                end
              end
            end else begin
              e.data  = mmem[idx];
              e.known = (mkb[idx] == 4'hF);
            end
            q.push_back(e);
          end
          if (exp_dok) void'(q.pop_front());
        end
      end
    end
  end

  // Drives a request and holds it until accepted; returns at the accepting negedge.
  task automatic issue(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] sz, output longint acc);
    @(posedge clk); #1;
    req[g] = 1'b1; wr[g] = w; addr[g] = a; wdata[g] = d; wstrb[g] = s; size[g] = sz;
    acc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (addr_ok[g]) begin
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL m%0d issue timeout: got no addr_ok want addr_ok", g);
    end
  endtask

  task automatic idle(input int g);
    @(posedge clk); #1;
    req[g] = 1'b0; stall_in[g] = 1'b0;
  endtask

  task automatic expect_dok(input int g, input string name, input longint ecyc,
                            input logic [31:0] edata);
    longint      c;
    logic [31:0] d;
    c = -1; d = 32'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_ok[g]) begin
        c = cyc; d = rdata[g];
        break;
      end
    end
    chk({name, " cycle"}, 32'(c), 32'(ecyc));
    chk({name, " data"}, d, edata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    longint      t0, t1, a, b, w, p, bb, aa, ar, first, acc;
    logic [9:0]  accb, dokb;

    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; req[g] = 1'b1; wr[g] = 1'b0; size[g] = 2'd2; wstrb[g] = 4'h0;
      addr[g] = 32'h0; wdata[g] = 32'h0; stall_in[g] = 1'b0;
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset addr_ok m%0d", g), 32'(addr_ok[g]), 32'h0);
      chk($sformatf("reset data_ok m%0d", g), 32'(data_ok[g]), 32'h0);
      chk($sformatf("reset rdata m%0d", g), rdata[g], 32'h0);
    end
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b0; req[g] = 1'b0;
    end

    // Single write then read, LATENCY=2
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'd2, t0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 2'd2, t1);
    chk("wr-rd read accept cycle", 32'(t1), 32'(t0 + 1));
    idle(0);
    expect_dok(0, "wr resp", t0 + 2, 32'h0);
    expect_dok(0, "rd resp", t0 + 4, 32'hDEADBEEF);

    // Byte strobes
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 2'd2, a);
    issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2'd2, acc);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 2'd2, acc);
    idle(0);
    expect_dok(0, "strobe wr2 resp", a + 4, 32'h0);
    expect_dok(0, "strobe rd", a + 6, 32'h11BB33DD);
    issue(0, 1'b1, 32'h23, 32'h99000000, 4'b1000, 2'd0, b);
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 2'd2, acc);
    idle(0);
    expect_dok(0, "byte wr resp", b + 2, 32'h0);
    expect_dok(0, "byte rd", b + 4, 32'h99BB33DD);

    // stall_in blocks acceptance
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h10; stall_in[0] = 1'b1;
      @(negedge clk);
      chk("stall addr_ok", 32'(addr_ok[0]), 32'h0);
      chk("stall data_ok", 32'(data_ok[0]), 32'h0);
    end
    idle(0);

    // Address wrap: 0x1000 aliases word 0
    issue(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 2'd2, w);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 2'd2, acc);
    idle(0);
    expect_dok(0, "wrap wr resp", w + 2, 32'h0);
    expect_dok(0, "wrap rd", w + 4, 32'hCAFEF00D);

    // Full back-pressure, LATENCY=8
    issue(1, 1'b1, 32'h40, 32'h5A5A1234, 4'hF, 2'd2, p);
    idle(1);
    expect_dok(1, "l8 single wr", p + 8, 32'h0);
    @(posedge clk); #1;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40;
    bb = cyc;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      accb[k] = addr_ok[1];
      dokb[k] = data_ok[1];
      if (k == 8) chk("full first rdata", rdata[1], 32'h5A5A1234);
      if (k < 9) @(posedge clk);
    end
    idle(1);
    chk("full accept pattern", 32'(accb), 32'h20F);
    chk("full data_ok pattern", 32'(dokb), 32'h100);
    expect_dok(1, "full resp2", bb + 16, 32'h5A5A1234);
    expect_dok(1, "full resp3", bb + 24, 32'h5A5A1234);
    expect_dok(1, "full resp4", bb + 32, 32'h5A5A1234);
    expect_dok(1, "full resp5", bb + 40, 32'h5A5A1234);

    // Reset mid-flight discards pending responses, keeps memory
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 2'd2, aa);
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 2'd2, acc);
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 2'd2, acc);
    idle(1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0; req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h40;
    @(negedge clk);
    ar = cyc;
    chk("post-reset addr_ok", 32'(addr_ok[1]), 32'h1);
    chk("post-reset accept cycle", 32'(ar), 32'(aa + 5));
    idle(1);
    expect_dok(1, "post-reset read", ar + 8, 32'h5A5A1234);

    // LATENCY=1 streaming
    for (int i = 0; i < 16; i++) begin
      issue(2, 1'b1, 32'(i * 4), 32'(i), 4'hF, 2'd2, acc);
    end
    idle(2);
    repeat (3) @(posedge clk);
    first = -1;
    for (int i = 0; i < 16; i++) begin
      issue(2, 1'b0, 32'(i * 4), 32'h0, 4'h0, 2'd2, acc);
      if (i == 0) begin
        first = acc;
      end else begin
        chk("stream accept cycle", 32'(acc), 32'(first + i));
        chk("stream data_ok", 32'(data_ok[2]), 32'h1);
        chk("stream rdata", rdata[2], 32'(i - 1));
      end
    end
    idle(2);
    @(negedge clk);
    chk("stream last data_ok", 32'(data_ok[2]), 32'h1);
    chk("stream last rdata", rdata[2], 32'd15);
    @(negedge clk);
    chk("stream drained", 32'(data_ok[2]), 32'h0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
- Responder end of the core's SRAM-like request/addr_ok/data_ok interface.
- Attaches directly to the inst_sram_* or data_sram_* port group of the CPU top.
- Models a word-organised memory that accepts pipelined requests, commits writes with byte strobes, and returns in-order responses after a programmable latency.
- Used as the bench and FPGA stand-in for the memory side until the AXI bridge lands.

Parameters:
- ADDR_W, 10, word-address bits; memory holds 2^ADDR_W 32-bit words.
- MAX_OUTSTANDING, 4, accepted-but-unanswered request capacity; power of two, >=2.
- LATENCY, 2, cycles from a request reaching FIFO head to its data_ok; >=1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid from the core.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; recorded only; wstrb governs byte enables.
- wstrb  in  4  byte write enables; meaningful only when wr=1.
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; upper bits ignored, so addresses wrap.
- wdata  in  32  write data.
- stall_in  in  1  bench back-pressure; forces addr_ok low.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  one-cycle response pulse, in request order.
- rdata  out  32  read data; valid when data_ok=1; 0 for write responses.

Behaviour:
- **addr_ok:** combinational; addr_ok = req & ~stall_in & ~full & ~reset. There is no path from data_ok to addr_ok.
  - When full, no request is accepted, even in a cycle where data_ok pops the FIFO.
- **Acceptance at edge T (req & addr_ok):**
  - Write: for each i with wstrb[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i] at edge T. An entry {wr=1, data=0} is pushed.
  - Read: the array is read combinationally in cycle T, reflecting all writes committed at earlier edges. An entry {wr=0, data=mem[idx]} is pushed.
  - Read data is snapshotted at acceptance. A later write to the same word does not alter an already-accepted read.
- **Response FIFO:**
  - Circular buffer of MAX_OUTSTANDING entries with a count register of width log2(MAX_OUTSTANDING)+1.
  - full = (count == MAX_OUTSTANDING); empty = (count == 0).
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- **Latency counter lat_cnt:**
  - Loads LATENCY-1 at the edge where an entry becomes head: a push into an empty FIFO, or a pop that leaves count >= 1.
  - Decrements while non-empty and >0.
  - With the FIFO empty at edge T, the request accepted at T produces data_ok during cycle T+LATENCY.
  - Subsequent heads respond LATENCY cycles after the previous data_ok, so LATENCY=1 gives back-to-back data_ok every cycle.
- **data_ok / rdata:** registered outputs.
  - data_ok=1 for exactly one cycle per entry, with rdata = head.data. The entry pops at the end of that cycle.
  - When data_ok=0, rdata holds its last value.
- **Reset:**
  - data_ok=0, rdata=0, count=0, pointers=0, lat_cnt=0; addr_ok is 0 while reset is high.
  - Reset mid-operation discards all pending responses; no data_ok follows for them.
  - Writes already accepted stay in memory; the memory array is never cleared.
- **Ordering:** strictly in acceptance order; reads and writes share one FIFO.
- **Ignored requests:** req with stall_in=1 or full is not accepted; the core must hold it. Nothing is recorded.

Test Plan:
- **Single write then read:** LATENCY=2. Write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF accepted at T0 -> data_ok in cycle T0+2 with rdata=0. Read addr=0x10 accepted at T0+1 -> data_ok at T0+4 with rdata=0xDEADBEEF.
- **Byte strobes:** word 0x20=0x11223344, then write wdata=0xAABBCCDD, wstrb=4'b0101 -> subsequent read returns 0x11BB33DD. A size=0 byte write with wstrb=4'b1000 changes only byte 3.
- **Full back-pressure:** MAX_OUTSTANDING=4, LATENCY=8, req held high -> exactly 4 accepts in 4 consecutive cycles, then addr_ok=0. addr_ok rises only in the cycle after the first data_ok. Responses come in order: 4 data_ok pulses spaced 8 cycles apart.
- **LATENCY=1 streaming:** reads of words 0..15 (preloaded with value = index) issued every cycle -> data_ok high continuously from the cycle after the first accept, rdata = 0,1,...,15 in order, no gaps.
- **stall_in and wrap:** stall_in=1 for 3 cycles with req=1 -> addr_ok=0, no data_ok. Also, addr=0x1000 with ADDR_W=10 aliases word 0: a write to 0x1000 is read back at 0x0.
- **Reset mid-flight:** 3 reads accepted, reset asserted for 1 cycle before the first data_ok -> no data_ok afterward, count=0, addr_ok=1 the cycle after reset deasserts. Data written before reset is still readable.
